// File: rtl/io_responder.sv
// Peripheral-side IO responder: 14 general ports, IRQ enable/pending registers,
// edge-triggered interrupt capture, vector selection and return-address storage.
module io_responder #(
  parameter int          NUM_IRQ     = 8,
  parameter logic [15:0] VECTOR_BASE = 16'hFF00
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         io_addr,
  input  logic               io_addr_read,
  input  logic               io_read,
  input  logic               io_push,
  input  logic               io_write,
  input  logic               io_store_retaddr,
  input  logic               io_push_retaddr,
  input  logic               io_push_ints,
  input  logic               io_push_int_addr,
  output logic               io_interrupt,
  output logic [15:0]        io_int_addr,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic [223:0]       port_in,
  output logic [223:0]       port_out,
  output logic [13:0]        port_wr_stb,
  output logic [13:0]        port_rd_stb,
  inout  wire  [15:0]        d_bus
);

  localparam int NPORT = 14;

  logic [NPORT-1:0][15:0] portOut_q, portOut_d;
  logic [NPORT-1:0][15:0] portIn;
  logic [15:0]            rdBuf_q, rdBuf_d;
  logic [15:0]            retaddr_q, retaddr_d;
  logic [NUM_IRQ-1:0]     enable_q, enable_d;
  logic [NUM_IRQ-1:0]     pending_q, pending_d;
  logic [NUM_IRQ-1:0]     irq_q;
  logic [3:0]             activeId_q, activeId_d;
  logic [NPORT-1:0]       wrStb_q, wrStb_d;
  logic [NPORT-1:0]       rdStb_q, rdStb_d;
  logic                   interrupt_q;

  logic                   isPort;
  logic [NUM_IRQ-1:0]     masked;
  logic [NUM_IRQ-1:0]     rise;
  logic [NUM_IRQ-1:0]     w1cClr;
  logic [NUM_IRQ-1:0]     ackClr;
  logic [3:0]             selId;
  logic                   anySel;
  logic [15:0]            enWide;
  logic [15:0]            pendWide;
  logic [15:0]            maskWide;
  logic                   busEn;
  logic [15:0]            busVal;
  logic                   unused_sig;

  assign portIn     = port_in;
  assign unused_sig = ^{io_push_int_addr, io_addr_read};

  // Lowest-index pending-and-enabled request wins the vector.
  always_comb begin
    masked = pending_q & enable_q;
    rise   = irq_in & ~irq_q;
    selId  = '0;
    anySel = 1'b0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) begin
        selId  = 4'(i);
        anySel = 1'b1;
      end
    end
    enWide   = '0;
    pendWide = '0;
    maskWide = '0;
    enWide[NUM_IRQ-1:0]   = enable_q;
    pendWide[NUM_IRQ-1:0] = pending_q;
    maskWide[NUM_IRQ-1:0] = masked;
  end

  always_comb begin
    isPort     = (io_addr < 4'(NPORT));
    portOut_d  = portOut_q;
    rdBuf_d    = rdBuf_q;
    retaddr_d  = retaddr_q;
    enable_d   = enable_q;
    activeId_d = activeId_q;
    wrStb_d    = '0;
    rdStb_d    = '0;
    w1cClr     = '0;
    ackClr     = '0;

    if (io_read) begin
      if (isPort) begin
        rdBuf_d          = portIn[io_addr];
        rdStb_d[io_addr] = 1'b1;
      end else if (io_addr == 4'd14) begin
        rdBuf_d = enWide;
      end else begin
        rdBuf_d = pendWide;
      end
    end

    if (io_write) begin
      if (isPort) begin
        portOut_d[io_addr] = d_bus;
        wrStb_d[io_addr]   = 1'b1;
      end else if (io_addr == 4'd14) begin
        enable_d = d_bus[NUM_IRQ-1:0];
      end else begin
        w1cClr = d_bus[NUM_IRQ-1:0];
      end
    end

    if (io_store_retaddr) begin
      retaddr_d = d_bus;
      if (anySel) begin
        activeId_d = selId;
        for (int i = 0; i < NUM_IRQ; i++) begin
          ackClr[i] = (selId == 4'(i));
        end
      end
    end

    // A fresh edge always survives a clear landing in the same cycle.
    pending_d = (pending_q & ~w1cClr & ~ackClr) | rise;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      portOut_q   <= '0;
      rdBuf_q     <= '0;
      retaddr_q   <= '0;
      enable_q    <= '0;
      pending_q   <= '0;
      irq_q       <= '0;
      activeId_q  <= '0;
      wrStb_q     <= '0;
      rdStb_q     <= '0;
      interrupt_q <= 1'b0;
    end else begin
      portOut_q   <= portOut_d;
      rdBuf_q     <= rdBuf_d;
      retaddr_q   <= retaddr_d;
      enable_q    <= enable_d;
      pending_q   <= pending_d;
      irq_q       <= irq_in;
      activeId_q  <= activeId_d;
      wrStb_q     <= wrStb_d;
      rdStb_q     <= rdStb_d;
      interrupt_q <= |masked;
    end
  end

  // Bus is driven only for a single legal push; priority only picks the value.
  always_comb begin
    busEn = rst_n && $onehot({io_push_retaddr, io_push, io_push_ints});
    if (io_push_retaddr) begin
      busVal = retaddr_q;
    end else if (io_push) begin
      busVal = rdBuf_q;
    end else begin
      busVal = maskWide;
    end
  end

  assign d_bus        = busEn ? busVal : 16'hzzzz;
  assign port_out     = portOut_q;
  assign port_wr_stb  = wrStb_q;
  assign port_rd_stb  = rdStb_q;
  assign io_interrupt = interrupt_q;
  assign io_int_addr  = VECTOR_BASE + {12'h000, activeId_q};

  pushExclusive: assert property (@(posedge clk) disable iff (!rst_n)
    $countones({io_push, io_push_retaddr, io_push_ints}) <= 1)
    else $error("io_responder: more than one bus push strobe asserted");

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: table-driven port reads/writes with a
// read-data scoreboard, plus directed interrupt, clear-race and reset sequences.
module tb_io_responder;

  localparam int NUM_IRQ = 8;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] pin;
    logic [15:0] expData;
    logic [13:0] expStb;
  } rdVec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
    logic [13:0] expStb;
  } wrVec_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         io_addr;
  logic               io_addr_read, io_read, io_push, io_write;
  logic               io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr;
  logic               io_interrupt;
  logic [15:0]        io_int_addr;
  logic [NUM_IRQ-1:0] irq_in;
  logic [223:0]       port_in;
  logic [223:0]       port_out;
  logic [13:0]        port_wr_stb, port_rd_stb;
  tri1  [15:0]        d_bus;

  logic               tbDrive;
  logic [15:0]        tbVal;
  logic [13:0][15:0]  expPort;
  logic [15:0]        sbQ[$];
  int                 checks = 0;
  int                 failures = 0;

  assign d_bus = tbDrive ? tbVal : 16'hzzzz;

  always #5 clk = ~clk;

  io_responder #(.NUM_IRQ(NUM_IRQ), .VECTOR_BASE(16'hFF00)) dut (
    .clk(clk), .rst_n(rst_n), .io_addr(io_addr), .io_addr_read(io_addr_read),
    .io_read(io_read), .io_push(io_push), .io_write(io_write),
    .io_store_retaddr(io_store_retaddr), .io_push_retaddr(io_push_retaddr),
    .io_push_ints(io_push_ints), .io_push_int_addr(io_push_int_addr),
    .io_interrupt(io_interrupt), .io_int_addr(io_int_addr), .irq_in(irq_in),
    .port_in(port_in), .port_out(port_out), .port_wr_stb(port_wr_stb),
    .port_rd_stb(port_rd_stb), .d_bus(d_bus)
  );

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one clock edge worth of strobes; irq_in is left at the given level.
  task automatic applyStimulus(input logic [3:0] addr, input logic rd, input logic wr,
                               input logic st, input logic [15:0] data,
                               input logic [NUM_IRQ-1:0] irq);
    io_addr          = addr;
    io_addr_read     = rd | wr;
    io_read          = rd;
    io_write         = wr;
    io_store_retaddr = st;
    tbDrive          = wr | st;
    tbVal            = data;
    irq_in           = irq;
    @(posedge clk);
    #1;
    io_read          = 1'b0;
    io_write         = 1'b0;
    io_store_retaddr = 1'b0;
    io_addr_read     = 1'b0;
    tbDrive          = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0000, irq_in);
  endtask

  task automatic popCompare(input string name);
    logic [15:0] exp;
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected scoreboard entry (queue empty)", name, d_bus);
    end else begin
      exp = sbQ.pop_front();
      if (d_bus !== exp) begin
        failures++;
        $display("[TB] FAIL %s: got %0h expected %0h", name, d_bus, exp);
      end
    end
  endtask

  task automatic doRead(input string name, input logic [3:0] addr,
                        input logic [15:0] expData, input logic [13:0] expStb);
    sbQ.push_back(expData);
    applyStimulus(addr, 1'b1, 1'b0, 1'b0, 16'h0000, irq_in);
    checkOutput({name, " rd_stb"}, port_rd_stb, expStb);
    io_push = 1'b1;
    #1;
    popCompare({name, " data"});
    @(posedge clk);
    #1;
    io_push = 1'b0;
    checkOutput({name, " rd_stb clear"}, port_rd_stb, 14'h0);
    #1;
    checkOutput({name, " bus idle"}, d_bus, 16'hFFFF);
  endtask

  task automatic doWrite(input string name, input logic [3:0] addr,
                         input logic [15:0] data, input logic [13:0] expStb);
    applyStimulus(addr, 1'b0, 1'b1, 1'b0, data, irq_in);
    if (addr < 4'd14) expPort[addr] = data;
    checkOutput({name, " port_out"}, port_out, expPort);
    checkOutput({name, " wr_stb"}, port_wr_stb, expStb);
    idle(1);
    checkOutput({name, " wr_stb clear"}, port_wr_stb, 14'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rdVec_t rdTab[6];
    wrVec_t wrTab[4];

    rdTab[0] = '{4'd3,  16'hBEEF, 16'hBEEF, 14'h0008};
    rdTab[1] = '{4'd0,  16'h0001, 16'h0001, 14'h0001};
    rdTab[2] = '{4'd13, 16'h8001, 16'h8001, 14'h2000};
    rdTab[3] = '{4'd7,  16'h7E7E, 16'h7E7E, 14'h0080};
    rdTab[4] = '{4'd14, 16'hFFFF, 16'h0000, 14'h0000};
    rdTab[5] = '{4'd15, 16'hFFFF, 16'h0000, 14'h0000};
    wrTab[0] = '{4'd5,  16'h1234, 14'h0020};
    wrTab[1] = '{4'd0,  16'hA5A5, 14'h0001};
    wrTab[2] = '{4'd13, 16'hFFFF, 14'h2000};
    wrTab[3] = '{4'd5,  16'h0F0F, 14'h0020};

    rst_n = 1'b0;
    io_addr = '0; io_addr_read = 0; io_read = 0; io_push = 0; io_write = 0;
    io_store_retaddr = 0; io_push_retaddr = 0; io_push_ints = 0; io_push_int_addr = 0;
    irq_in = '0; port_in = '0; tbDrive = 0; tbVal = '0; expPort = '0;

    idle(2);
    checkOutput("reset port_out", port_out, 224'h0);
    checkOutput("reset wr_stb", port_wr_stb, 14'h0);
    checkOutput("reset rd_stb", port_rd_stb, 14'h0);
    checkOutput("reset interrupt", io_interrupt, 1'b0);
    checkOutput("reset int_addr", io_int_addr, 16'hFF00);
    checkOutput("reset bus idle", d_bus, 16'hFFFF);
    rst_n = 1'b1;
    idle(1);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 14; k++) port_in[16*k +: 16] = 16'h5555;
      if (rdTab[i].addr < 4'd14) port_in[16*rdTab[i].addr +: 16] = rdTab[i].pin;
      doRead($sformatf("read%0d addr%0d", i, rdTab[i].addr), rdTab[i].addr,
             rdTab[i].expData, rdTab[i].expStb);
    end

    for (int i = 0; i < 4; i++) begin
      doWrite($sformatf("write%0d addr%0d", i, wrTab[i].addr), wrTab[i].addr,
              wrTab[i].data, wrTab[i].expStb);
    end

    // Two simultaneous edges, enable 0x06: lowest (bit 1) is acknowledged first.
    doWrite("enable 06", 4'd14, 16'h0006, 14'h0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h06);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    checkOutput("irq raised", io_interrupt, 1'b1);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 16'h0042, 8'h00);
    checkOutput("ack vector", io_int_addr, 16'hFF01);
    idle(1);
    checkOutput("irq still pending", io_interrupt, 1'b1);
    io_push_retaddr = 1'b1;
    #1;
    checkOutput("push retaddr", d_bus, 16'h0042);
    io_push_retaddr = 1'b0;
    io_push_ints = 1'b1;
    #1;
    checkOutput("push ints", d_bus, 16'h0004);
    io_push_ints = 1'b0;
    doRead("pending after ack", 4'd15, 16'h0004, 14'h0);
    doRead("enable readback", 4'd14, 16'h0006, 14'h0);

    // Masked edge stays pending until enabled, then write-1-to-clear.
    doWrite("enable 00", 4'd14, 16'h0000, 14'h0);
    doWrite("clear all", 4'd15, 16'h00FF, 14'h0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h01);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    idle(1);
    checkOutput("masked irq", io_interrupt, 1'b0);
    doRead("masked pending", 4'd15, 16'h0001, 14'h0);
    doWrite("enable 01", 4'd14, 16'h0001, 14'h0);
    checkOutput("unmasked irq", io_interrupt, 1'b1);
    checkOutput("vector unchanged", io_int_addr, 16'hFF01);
    doWrite("w1c bit0", 4'd15, 16'h0001, 14'h0);
    checkOutput("irq after w1c", io_interrupt, 1'b0);
    doRead("pending after w1c", 4'd15, 16'h0000, 14'h0);

    // Acknowledge with nothing pending only captures the return address.
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 16'h1357, 8'h00);
    checkOutput("empty ack vector", io_int_addr, 16'hFF01);
    io_push_retaddr = 1'b1;
    #1;
    checkOutput("empty ack retaddr", d_bus, 16'h1357);
    io_push_retaddr = 1'b0;

    // Clears racing a fresh edge on the same bit: the edge wins.
    applyStimulus(4'd15, 1'b0, 1'b1, 1'b0, 16'h0008, 8'h08);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    doRead("w1c vs edge", 4'd15, 16'h0008, 14'h0);
    doWrite("enable 08", 4'd14, 16'h0008, 14'h0);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b1, 16'h00AA, 8'h08);
    checkOutput("ack vs edge vector", io_int_addr, 16'hFF03);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    doRead("ack vs edge pending", 4'd15, 16'h0008, 14'h0);
    checkOutput("ack vs edge irq", io_interrupt, 1'b1);

    // Reset between io_read and io_push.
    port_in[16*3 +: 16] = 16'hBEEF;
    applyStimulus(4'd3, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00);
    rst_n = 1'b0;
    io_push = 1'b1;
    #1;
    checkOutput("reset bus z", d_bus, 16'hFFFF);
    applyStimulus(4'd0, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00);
    expPort = '0;
    checkOutput("midreset port_out", port_out, expPort);
    checkOutput("midreset rd_stb", port_rd_stb, 14'h0);
    checkOutput("midreset interrupt", io_interrupt, 1'b0);
    checkOutput("midreset int_addr", io_int_addr, 16'hFF00);
    rst_n = 1'b1;
    sbQ.delete();
    sbQ.push_back(16'h0000);
    #1;
    popCompare("midreset buffer");
    io_push = 1'b0;
    idle(1);
    doRead("midreset pending", 4'd15, 16'h0000, 14'h0);
    doRead("midreset enable", 4'd14, 16'h0000, 14'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Peripheral-side responder for the CPU's IO strobe interface; sits on the shared 16-bit d_bus opposite the instruction control unit.
- Services IO port reads and writes (ioi/ioo) with 14 general 16-bit ports plus two control registers.
- Detects and latches interrupt requests, raises io_interrupt, selects the vector, and stores/returns the interrupted PC for rit.

Parameters:
NUM_IRQ, 8, number of interrupt request inputs (1..16)
VECTOR_BASE, 16'hFF00, data-memory address of vector slot 0; slot k at VECTOR_BASE+k

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
io_addr  in  4  port address from control unit
io_addr_read  in  1  address-valid qualifier (accompanies io_read/io_write/io_push)
io_read  in  1  sample addressed port into read buffer
io_push  in  1  drive read buffer onto d_bus
io_write  in  1  latch d_bus into addressed port
io_store_retaddr  in  1  latch d_bus (PC) as return address; acknowledges interrupt
io_push_retaddr  in  1  drive return address onto d_bus
io_push_ints  in  1  drive pending&enable mask onto d_bus
io_push_int_addr  in  1  vector address select (memory address mux uses io_int_addr)
io_interrupt  out  1  interrupt request to control unit
io_int_addr  out  16  VECTOR_BASE + selected irq id
irq_in  in  NUM_IRQ  interrupt sources, rising-edge sensitive
port_in  in  224  14 x 16-bit input ports, port k at bits [16k+15:16k]
port_out  out  224  14 x 16-bit output port registers, same packing
port_wr_stb  out  14  one-cycle pulse, port k written
port_rd_stb  out  14  one-cycle pulse, port k sampled
d_bus  inout  16  shared data bus

Behaviour:
- Reset (rst_n=0 at posedge): port_out=0, read buffer=0, retaddr=0, enable=0, pending=0, irq_in history=0, active id=0, strobes=0, io_interrupt=0, d_bus=Z.
- Address map: 0..13 general ports; 14 = IRQ enable (R/W, low NUM_IRQ bits, upper bits read 0); 15 = IRQ pending (read; write-1-to-clear).
- Read: posedge with io_read=1 -> read buffer <= value at io_addr (port_in[k], enable, or pending); port_rd_stb[k] pulses next cycle for k<14. Next cycle io_push=1 -> d_bus = read buffer combinationally. One-cycle latency read-to-push; buffer holds until next io_read.
- Write: posedge with io_write=1 -> d_bus sampled into port_out[k]/enable/pending-clear; port_wr_stb[k] pulses for one cycle after.
- d_bus driven only while exactly one of io_push, io_push_retaddr, io_push_ints is high; otherwise Z. Multiple high at once is illegal; priority io_push_retaddr > io_push > io_push_ints; assertion flags it.
- Edge detect: irq_q <= irq_in; pending[i] set when irq_in[i]&~irq_q[i].
- io_interrupt = |(pending & enable), registered (one-cycle lag).
- Selection: lowest-index bit of pending&enable -> sel id, combinational; io_int_addr = VECTOR_BASE + active id.
- Acknowledge: posedge with io_store_retaddr=1 -> retaddr <= d_bus; active id <= sel id; pending[sel id] cleared. New edge on the same bit in the same cycle -> bit stays set (set wins). io_interrupt re-evaluates the following cycle.
- io_store_retaddr with nothing pending: retaddr captured, active id unchanged, no clear.
- io_push_retaddr: drives retaddr; no state change. Nesting not supported; a second acknowledge overwrites retaddr.
- Pending write-1-to-clear concurrent with a new edge on the same bit -> set wins.
- Reset mid-transaction (between io_read and io_push) -> buffer 0; d_bus Z.

Test Plan:
- Reset then io_read addr 3 with port_in[3]=16'hBEEF, next cycle io_push -> d_bus=16'hBEEF, port_rd_stb[3] pulses once; idle cycles -> d_bus=Z.
- io_write addr 5 with d_bus=16'h1234 -> port_out[5]=16'h1234, port_wr_stb=14'h0020 for one cycle, other ports unchanged.
- Write enable=8'h06, pulse irq_in[2] and irq_in[1] same cycle -> io_interrupt=1 next cycle; io_store_retaddr with d_bus=16'h0042 -> io_int_addr=16'hFF01, pending=8'h04; io_interrupt stays 1.
- io_push_retaddr after ack -> d_bus=16'h0042; io_push_ints -> d_bus=16'h0004.
- irq_in[0] edge with enable=0 -> io_interrupt=0, pending bit0=1; write enable=1 -> io_interrupt=1 next cycle; write 1 to addr 15 bit0 -> cleared.
- Write-1-to-clear bit 3 in same cycle as new irq_in[3] edge -> pending[3]=1; rst_n=0 mid-read -> all outputs return to reset values.
